pcie_ltssm_controller: RTL and testbench
========================================

PCIE_LTSSM_CONTROLLER -- requirements
Module: pcie_ltssm_controller

Interface
REQ-001 SHALL have parameter TS1_TX_COUNT, default 1024: TS1s to send in POLL_ACTIVE before exit.
REQ-002 SHALL have parameter TS_RX_COUNT, default 8: consecutive qualifying received TSs required to exit POLL_ACTIVE, POLL_CONFIG and CFG_COMPLETE.
REQ-003 SHALL have parameter TS2_POST_COUNT, default 16: TS2s to send after the first qualifying received TS2.
REQ-004 SHALL have parameter IDLE_RX_COUNT, default 8, and IDLE_TX_COUNT, default 16: the CFG_IDLE idle thresholds.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 3000000: per-state timeout in clk cycles (24 ms at 125 MHz).
REQ-006 SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: sole clock.
- rst_n, in, 1: reset; synchronous, active-low.
- rx_ts1_valid, in, 1: one-cycle pulse, TS1 received.
- rx_ts2_valid, in, 1: one-cycle pulse, TS2 received.
- rx_ts_link_valid, in, 1, and rx_ts_link, in, 5: received link number and its valid flag.
- rx_ts_lane_valid, in, 1, and rx_ts_lane, in, 5: received lane number and its valid flag.
- rx_idle_valid, in, 1: pulse, logical-idle symbol pair received.
- tx_ts_sent, in, 1: pulse, generator finished one TS.
- tx_idle_sent, in, 1: pulse, generator sent one idle pair.
- tx_mode, out, 2: 0=TS1, 1=TS2, 2=logical idle; 3 is never driven.
- tx_ts_link_valid, out, 1, and tx_ts_link, out, 5: transmitted link field.
- tx_ts_lane_valid, out, 1, and tx_ts_lane, out, 5: transmitted lane field.
- link_id, out, 5, and lane_id, out, 5: latched link and lane numbers.
- link_up, out, 1: high only in L0.
- ltssm_state, out, 4: current state encoding.
- retrain_count, out, 8: saturating count of L0 to DETECT exits.

Function
REQ-007 SHALL use this state encoding: DETECT=0, POLL_ACTIVE=1, POLL_CONFIG=2, CFG_LW_START=3, CFG_LW_ACCEPT=4, CFG_COMPLETE=5, CFG_IDLE=6, L0=7; all other codes are unreachable.
REQ-008 SHALL make all outputs registered.
REQ-009 SHALL update outputs one cycle after the qualifying input pulse.
REQ-010 SHALL make every counter saturating at its threshold: no wrap-around.
REQ-011 SHALL clear all counters and the timer on every state transition.
REQ-012 SHALL run a timer that increments each cycle in states 1-6 and expires when it reaches TIMEOUT_CYCLES-1.
REQ-013 SHALL give a same-cycle exit condition priority over timer expiry.
REQ-014 In DETECT, SHALL set tx_mode=0, clear link/lane valid, and move to POLL_ACTIVE after exactly one cycle.
REQ-015 In POLL_ACTIVE, SHALL count tx_ts_sent pulses.
REQ-016 In POLL_ACTIVE, SHALL count received TS1 or TS2 with link and lane both invalid; any other received TS resets this count.
REQ-017 In POLL_ACTIVE, SHALL go to POLL_CONFIG when sent>=TS1_TX_COUNT and recv>=TS_RX_COUNT.
REQ-018 On POLL_ACTIVE expiry, SHALL go to POLL_CONFIG if recv>=1, else to DETECT.
REQ-019 In POLL_CONFIG, SHALL set tx_mode=1 and count received TS2s with link and lane invalid.
REQ-020 In POLL_CONFIG, SHALL count tx_ts_sent only after the first such TS2.
REQ-021 In POLL_CONFIG, SHALL go to CFG_LW_START when recv>=TS_RX_COUNT and post-sent>=TS2_POST_COUNT; expiry goes to DETECT.
REQ-022 In CFG_LW_START, SHALL set tx_mode=0 with link and lane invalid.
REQ-023 In CFG_LW_START, on two consecutive TS1s with link valid, lane invalid and equal link numbers, SHALL latch link_id, set tx_ts_link=link_id with tx_ts_link_valid=1, and go to CFG_LW_ACCEPT.
REQ-024 In CFG_LW_START, a link number mismatch SHALL restart the pair using the new number; expiry goes to DETECT.
REQ-025 In CFG_LW_ACCEPT, on a TS1 with link valid equal to link_id and lane valid, SHALL latch lane_id, echo it with tx_ts_lane_valid=1, and go to CFG_COMPLETE.
REQ-026 In CFG_LW_ACCEPT, a TS1 with link invalid SHALL return the block to CFG_LW_START with tx link invalid; expiry goes to DETECT.
REQ-027 In CFG_COMPLETE, SHALL set tx_mode=1 and count consecutive TS2s whose link and lane match the latched values.
REQ-028 In CFG_COMPLETE, SHALL count sent TS2s after the first match.
REQ-029 In CFG_COMPLETE, SHALL go to CFG_IDLE when recv>=TS_RX_COUNT and post-sent>=TS2_POST_COUNT; expiry goes to DETECT.
REQ-030 In CFG_IDLE, SHALL set tx_mode=2 and count consecutive rx_idle_valid; any received TS resets this count.
REQ-031 In CFG_IDLE, SHALL count tx_idle_sent after the first idle; go to L0 when counts reach IDLE_RX_COUNT and IDLE_TX_COUNT; expiry goes to DETECT.
REQ-032 In L0, SHALL hold link_up=1 and tx_mode=2, with no timer.
REQ-033 In L0, a received TS1 SHALL send the block to DETECT and increment retrain_count.

Reset
REQ-034 rst_n low at a clk edge SHALL take priority over all other events, mid-operation included.
REQ-035 While rst_n is low, SHALL force: ltssm_state=DETECT, tx_mode=0, all link/lane valid=0, all link/lane values=0, link_up=0, retrain_count=0, all counters and timer=0.

Verification
REQ-036 Full training: 1024 tx_ts_sent pulses plus 8 TS2 with link/lane invalid, then the CFG sequences with link 5, lane 0, then 8 idles -> link_up=1, link_id=5, lane_id=0, ltssm_state=7.
REQ-037 POLL_ACTIVE with no received TS, TIMEOUT_CYCLES=100 -> DETECT at cycle 100, then POLL_ACTIVE one cycle later.
REQ-038 CFG_LW_START receiving TS1 with link 3, then 4, then 4 -> link_id=4 and exit only after the second 4.
REQ-039 In L0, inject one TS1 -> link_up=0, ltssm_state=0, retrain_count=1.
REQ-040 Assert rst_n low during CFG_COMPLETE -> next cycle all outputs equal their REQ-035 values.

Source files
------------

// File: rtl/pcie_ltssm_controller.sv
// rtl/pcie_ltssm_controller.sv - PCIe LTSSM link training controller (DETECT through L0)
module pcie_ltssm_controller #(
    parameter int TS1_TX_COUNT   = 1024,
    parameter int TS_RX_COUNT    = 8,
    parameter int TS2_POST_COUNT = 16,
    parameter int IDLE_RX_COUNT  = 8,
    parameter int IDLE_TX_COUNT  = 16,
    parameter int TIMEOUT_CYCLES = 3000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_ts1_valid,
    input  logic       rx_ts2_valid,
    input  logic       rx_ts_link_valid,
    input  logic [4:0] rx_ts_link,
    input  logic       rx_ts_lane_valid,
    input  logic [4:0] rx_ts_lane,
    input  logic       rx_idle_valid,
    input  logic       tx_ts_sent,
    input  logic       tx_idle_sent,
    output logic [1:0] tx_mode,
    output logic       tx_ts_link_valid,
    output logic [4:0] tx_ts_link,
    output logic       tx_ts_lane_valid,
    output logic [4:0] tx_ts_lane,
    output logic [4:0] link_id,
    output logic [4:0] lane_id,
    output logic       link_up,
    output logic [3:0] ltssm_state,
    output logic [7:0] retrain_count
);

    localparam logic [3:0] ST_DETECT        = 4'd0;
    localparam logic [3:0] ST_POLL_ACTIVE   = 4'd1;
    localparam logic [3:0] ST_POLL_CONFIG   = 4'd2;
    localparam logic [3:0] ST_CFG_LW_START  = 4'd3;
    localparam logic [3:0] ST_CFG_LW_ACCEPT = 4'd4;
    localparam logic [3:0] ST_CFG_COMPLETE  = 4'd5;
    localparam logic [3:0] ST_CFG_IDLE      = 4'd6;
    localparam logic [3:0] ST_L0            = 4'd7;

    localparam logic [1:0] MODE_TS1  = 2'd0;
    localparam logic [1:0] MODE_TS2  = 2'd1;
    localparam logic [1:0] MODE_IDLE = 2'd2;

    localparam logic [15:0] TS1_TX_MAX   = 16'(TS1_TX_COUNT);
    localparam logic [15:0] TS_RX_MAX    = 16'(TS_RX_COUNT);
    localparam logic [15:0] TS2_POST_MAX = 16'(TS2_POST_COUNT);
    localparam logic [15:0] IDLE_RX_MAX  = 16'(IDLE_RX_COUNT);
    localparam logic [15:0] IDLE_TX_MAX  = 16'(IDLE_TX_COUNT);
    localparam logic [31:0] TIMER_LAST   = 32'(TIMEOUT_CYCLES - 1);

    // Counters never wrap: they stick at their threshold.
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] lim);
        return (v >= lim) ? v : v + 16'd1;
    endfunction

    logic [3:0]  state_q, state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;     // TS1 sent / TS2 post-sent / idle sent
    logic [15:0] rx_cnt_q, rx_cnt_d;     // qualifying TS received / idles received
    logic        seen_q, seen_d;         // first qualifying receive seen in this state
    logic [4:0]  cand_link_q, cand_link_d;
    logic [31:0] timer_q, timer_d;
    logic [1:0]  tx_mode_q, tx_mode_d;
    logic        tx_link_v_q, tx_link_v_d;
    logic [4:0]  tx_link_q, tx_link_d;
    logic        tx_lane_v_q, tx_lane_v_d;
    logic [4:0]  tx_lane_q, tx_lane_d;
    logic [4:0]  link_id_q, link_id_d;
    logic [4:0]  lane_id_q, lane_id_d;
    logic        link_up_q, link_up_d;
    logic [7:0]  retrain_q, retrain_d;

    logic rx_ts;
    logic timer_exp;
    logic pa_recv_ok;
    logic pc_recv_ok;
    logic pair_hit;
    logic lane_hit;
    logic link_lost;
    logic cc_match;

    assign rx_ts      = rx_ts1_valid | rx_ts2_valid;
    assign timer_exp  = (timer_q == TIMER_LAST);
    assign pa_recv_ok = !rx_ts_link_valid && !rx_ts_lane_valid;
    assign pc_recv_ok = rx_ts2_valid && !rx_ts_link_valid && !rx_ts_lane_valid;
    assign pair_hit   = rx_ts1_valid && rx_ts_link_valid && !rx_ts_lane_valid
                        && (rx_cnt_q != 16'd0) && (rx_ts_link == cand_link_q);
    assign lane_hit   = rx_ts1_valid && rx_ts_link_valid && rx_ts_lane_valid
                        && (rx_ts_link == link_id_q);
    assign link_lost  = rx_ts1_valid && !rx_ts_link_valid;
    assign cc_match   = rx_ts2_valid && rx_ts_link_valid && rx_ts_lane_valid
                        && (rx_ts_link == link_id_q) && (rx_ts_lane == lane_id_q);

    // Next-state, counter and output-register computation; exits are checked before timer expiry.
    always_comb begin
        state_d     = state_q;
        tx_cnt_d    = tx_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        seen_d      = seen_q;
        cand_link_d = cand_link_q;
        tx_link_v_d = tx_link_v_q;
        tx_link_d   = tx_link_q;
        tx_lane_v_d = tx_lane_v_q;
        tx_lane_d   = tx_lane_q;
        link_id_d   = link_id_q;
        lane_id_d   = lane_id_q;
        retrain_d   = retrain_q;
        timer_d     = timer_q;
        tx_mode_d   = MODE_TS1;
        link_up_d   = 1'b0;

        case (state_q)
            ST_DETECT: begin
                state_d = ST_POLL_ACTIVE;
            end
            ST_POLL_ACTIVE: begin
                if (tx_ts_sent) tx_cnt_d = sat_inc(tx_cnt_q, TS1_TX_MAX);
                if (rx_ts) rx_cnt_d = pa_recv_ok ? sat_inc(rx_cnt_q, TS_RX_MAX) : 16'd0;
                if (tx_cnt_d >= TS1_TX_MAX && rx_cnt_d >= TS_RX_MAX)
                    state_d = ST_POLL_CONFIG;
                else if (timer_exp)
                    state_d = (rx_cnt_d != 16'd0) ? ST_POLL_CONFIG : ST_DETECT;
            end
            ST_POLL_CONFIG: begin
                if (pc_recv_ok) begin
                    rx_cnt_d = sat_inc(rx_cnt_q, TS_RX_MAX);
                    seen_d   = 1'b1;
                end
                if (tx_ts_sent && seen_q) tx_cnt_d = sat_inc(tx_cnt_q, TS2_POST_MAX);
                if (rx_cnt_d >= TS_RX_MAX && tx_cnt_d >= TS2_POST_MAX)
                    state_d = ST_CFG_LW_START;
                else if (timer_exp)
                    state_d = ST_DETECT;
            end
            ST_CFG_LW_START: begin
                if (pair_hit) begin
                    state_d     = ST_CFG_LW_ACCEPT;
                    link_id_d   = rx_ts_link;
                    tx_link_d   = rx_ts_link;
                    tx_link_v_d = 1'b1;
                end else begin
                    if (rx_ts1_valid && rx_ts_link_valid && !rx_ts_lane_valid) begin
                        // First of a pair, or a mismatch restarting the pair on the new number.
                        cand_link_d = rx_ts_link;
                        rx_cnt_d    = 16'd1;
                    end else if (rx_ts) begin
                        rx_cnt_d = 16'd0;
                    end
                    if (timer_exp) state_d = ST_DETECT;
                end
            end
            ST_CFG_LW_ACCEPT: begin
                if (lane_hit) begin
                    state_d     = ST_CFG_COMPLETE;
                    lane_id_d   = rx_ts_lane;
                    tx_lane_d   = rx_ts_lane;
                    tx_lane_v_d = 1'b1;
                end else if (link_lost) begin
                    state_d = ST_CFG_LW_START;
                end else if (timer_exp) begin
                    state_d = ST_DETECT;
                end
            end
            ST_CFG_COMPLETE: begin
                if (cc_match) begin
                    rx_cnt_d = sat_inc(rx_cnt_q, TS_RX_MAX);
                    seen_d   = 1'b1;
                end else if (rx_ts) begin
                    rx_cnt_d = 16'd0;
                end
                if (tx_ts_sent && seen_q) tx_cnt_d = sat_inc(tx_cnt_q, TS2_POST_MAX);
                if (rx_cnt_d >= TS_RX_MAX && tx_cnt_d >= TS2_POST_MAX)
                    state_d = ST_CFG_IDLE;
                else if (timer_exp)
                    state_d = ST_DETECT;
            end
            ST_CFG_IDLE: begin
                if (rx_ts) begin
                    rx_cnt_d = 16'd0;
                end else if (rx_idle_valid) begin
                    rx_cnt_d = sat_inc(rx_cnt_q, IDLE_RX_MAX);
                    seen_d   = 1'b1;
                end
                if (tx_idle_sent && seen_q) tx_cnt_d = sat_inc(tx_cnt_q, IDLE_TX_MAX);
                if (rx_cnt_d >= IDLE_RX_MAX && tx_cnt_d >= IDLE_TX_MAX)
                    state_d = ST_L0;
                else if (timer_exp)
                    state_d = ST_DETECT;
            end
            ST_L0: begin
                if (rx_ts1_valid) begin
                    state_d   = ST_DETECT;
                    retrain_d = (retrain_q == 8'hFF) ? retrain_q : retrain_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_DETECT;
            end
        endcase

        // Every transition starts the new state with fresh counters.
        if (state_d != state_q) begin
            tx_cnt_d    = 16'd0;
            rx_cnt_d    = 16'd0;
            seen_d      = 1'b0;
            cand_link_d = 5'd0;
        end

        // Timer only runs in the training states 1-6.
        if (state_d != state_q || state_q == ST_DETECT || state_q == ST_L0)
            timer_d = 32'd0;
        else if (!timer_exp)
            timer_d = timer_q + 32'd1;

        // Link/lane fields are advertised only once negotiated in the configuration states.
        if (state_d == ST_DETECT || state_d == ST_POLL_ACTIVE ||
            state_d == ST_POLL_CONFIG || state_d == ST_CFG_LW_START) begin
            tx_link_v_d = 1'b0;
            tx_lane_v_d = 1'b0;
        end

        case (state_d)
            ST_POLL_CONFIG, ST_CFG_COMPLETE: tx_mode_d = MODE_TS2;
            ST_CFG_IDLE, ST_L0:              tx_mode_d = MODE_IDLE;
            default:                         tx_mode_d = MODE_TS1;
        endcase
        link_up_d = (state_d == ST_L0);
    end

    // State, counters and all output registers; reset wins over every other event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_DETECT;
            tx_cnt_q    <= 16'd0;
            rx_cnt_q    <= 16'd0;
            seen_q      <= 1'b0;
            cand_link_q <= 5'd0;
            timer_q     <= 32'd0;
            tx_mode_q   <= MODE_TS1;
            tx_link_v_q <= 1'b0;
            tx_link_q   <= 5'd0;
            tx_lane_v_q <= 1'b0;
            tx_lane_q   <= 5'd0;
            link_id_q   <= 5'd0;
            lane_id_q   <= 5'd0;
            link_up_q   <= 1'b0;
            retrain_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            seen_q      <= seen_d;
            cand_link_q <= cand_link_d;
            timer_q     <= timer_d;
            tx_mode_q   <= tx_mode_d;
            tx_link_v_q <= tx_link_v_d;
            tx_link_q   <= tx_link_d;
            tx_lane_v_q <= tx_lane_v_d;
            tx_lane_q   <= tx_lane_d;
            link_id_q   <= link_id_d;
            lane_id_q   <= lane_id_d;
            link_up_q   <= link_up_d;
            retrain_q   <= retrain_d;
        end
    end

    assign tx_mode          = tx_mode_q;
    assign tx_ts_link_valid = tx_link_v_q;
    assign tx_ts_link       = tx_link_q;
    assign tx_ts_lane_valid = tx_lane_v_q;
    assign tx_ts_lane       = tx_lane_q;
    assign link_id          = link_id_q;
    assign lane_id          = lane_id_q;
    assign link_up          = link_up_q;
    assign ltssm_state      = state_q;
    assign retrain_count    = retrain_q;

endmodule

// File: tb/tb_pcie_ltssm_controller.sv
// tb/tb_pcie_ltssm_controller.sv - directed self-checking bench for pcie_ltssm_controller
module tb_pcie_ltssm_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst_to_n;
    logic       rx_ts1_valid, rx_ts2_valid, rx_ts_link_valid, rx_ts_lane_valid;
    logic [4:0] rx_ts_link, rx_ts_lane;
    logic       rx_idle_valid, tx_ts_sent, tx_idle_sent;

    logic [1:0] tx_mode;
    logic       tx_ts_link_valid, tx_ts_lane_valid, link_up;
    logic [4:0] tx_ts_link, tx_ts_lane, link_id, lane_id;
    logic [3:0] ltssm_state;
    logic [7:0] retrain_count;

    logic [1:0] to_tx_mode;
    logic       to_tx_ts_link_valid, to_tx_ts_lane_valid, to_link_up;
    logic [4:0] to_tx_ts_link, to_tx_ts_lane, to_link_id, to_lane_id;
    logic [3:0] to_ltssm_state;
    logic [7:0] to_retrain_count;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pcie_ltssm_controller #(.TIMEOUT_CYCLES(4000)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_ts1_valid(rx_ts1_valid), .rx_ts2_valid(rx_ts2_valid),
        .rx_ts_link_valid(rx_ts_link_valid), .rx_ts_link(rx_ts_link),
        .rx_ts_lane_valid(rx_ts_lane_valid), .rx_ts_lane(rx_ts_lane),
        .rx_idle_valid(rx_idle_valid), .tx_ts_sent(tx_ts_sent), .tx_idle_sent(tx_idle_sent),
        .tx_mode(tx_mode), .tx_ts_link_valid(tx_ts_link_valid), .tx_ts_link(tx_ts_link),
        .tx_ts_lane_valid(tx_ts_lane_valid), .tx_ts_lane(tx_ts_lane),
        .link_id(link_id), .lane_id(lane_id), .link_up(link_up),
        .ltssm_state(ltssm_state), .retrain_count(retrain_count)
    );

    pcie_ltssm_controller #(.TIMEOUT_CYCLES(100)) dut_to (
        .clk(clk), .rst_n(rst_to_n),
        .rx_ts1_valid(rx_ts1_valid), .rx_ts2_valid(rx_ts2_valid),
        .rx_ts_link_valid(rx_ts_link_valid), .rx_ts_link(rx_ts_link),
        .rx_ts_lane_valid(rx_ts_lane_valid), .rx_ts_lane(rx_ts_lane),
        .rx_idle_valid(rx_idle_valid), .tx_ts_sent(tx_ts_sent), .tx_idle_sent(tx_idle_sent),
        .tx_mode(to_tx_mode), .tx_ts_link_valid(to_tx_ts_link_valid), .tx_ts_link(to_tx_ts_link),
        .tx_ts_lane_valid(to_tx_ts_lane_valid), .tx_ts_lane(to_tx_ts_lane),
        .link_id(to_link_id), .lane_id(to_lane_id), .link_up(to_link_up),
        .ltssm_state(to_ltssm_state), .retrain_count(to_retrain_count)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        rx_ts1_valid = 1'b0; rx_ts2_valid = 1'b0;
        rx_ts_link_valid = 1'b0; rx_ts_link = 5'd0;
        rx_ts_lane_valid = 1'b0; rx_ts_lane = 5'd0;
        rx_idle_valid = 1'b0; tx_ts_sent = 1'b0; tx_idle_sent = 1'b0;
    endtask

    task automatic send_ts(input logic is2, input logic lv, input logic [4:0] l,
                           input logic nv, input logic [4:0] n, input logic sent);
        rx_ts1_valid = !is2; rx_ts2_valid = is2;
        rx_ts_link_valid = lv; rx_ts_link = l;
        rx_ts_lane_valid = nv; rx_ts_lane = n;
        tx_ts_sent = sent;
        cyc();
        clr_in();
    endtask

    task automatic test_reset();
        logic [41:0] all_out;
        clr_in();
        rst_n = 1'b0; rst_to_n = 1'b0;
        cyc(); cyc();
        all_out = {ltssm_state, tx_mode, tx_ts_link_valid, tx_ts_link, tx_ts_lane_valid,
                   tx_ts_lane, link_id, lane_id, link_up, retrain_count};
        n_chk++;
        if (all_out !== 42'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        rst_n = 1'b1;
        cyc();
        n_chk++;
        if (ltssm_state !== 4'd1) begin
            n_fail++; $display("FAIL detect_exit: state got %0d expected 1", ltssm_state);
        end
    endtask

    task automatic test_timeout();
        rst_to_n = 1'b1;
        cyc();
        n_chk++;
        if (to_ltssm_state !== 4'd1) begin
            n_fail++; $display("FAIL to_enter_poll: state got %0d expected 1", to_ltssm_state);
        end
        repeat (99) cyc();
        n_chk++;
        if (to_ltssm_state !== 4'd1) begin
            n_fail++; $display("FAIL to_cycle99: state got %0d expected 1", to_ltssm_state);
        end
        cyc();
        n_chk++;
        if (to_ltssm_state !== 4'd0 || to_tx_mode !== 2'd0) begin
            n_fail++; $display("FAIL to_cycle100: state got %0d mode %0d expected 0 0", to_ltssm_state, to_tx_mode);
        end
        cyc();
        n_chk++;
        if (to_ltssm_state !== 4'd1) begin
            n_fail++; $display("FAIL to_cycle101: state got %0d expected 1", to_ltssm_state);
        end
        rst_to_n = 1'b0;
    endtask

    task automatic reach_cfg_lw_start();
        for (int i = 0; i < 1024; i++) begin
            tx_ts_sent = 1'b1;
            rx_ts2_valid = (i >= 1016);
            cyc();
            clr_in();
            if (i == 1022) begin
                n_chk++;
                if (ltssm_state !== 4'd1) begin
                    n_fail++; $display("FAIL poll_active_hold: state got %0d expected 1", ltssm_state);
                end
            end
        end
        n_chk++;
        if (ltssm_state !== 4'd2 || tx_mode !== 2'd1) begin
            n_fail++; $display("FAIL poll_config_entry: state got %0d mode %0d expected 2 1", ltssm_state, tx_mode);
        end
        rx_ts2_valid = 1'b1;
        cyc();
        clr_in();
        for (int i = 0; i < 16; i++) begin
            tx_ts_sent = 1'b1;
            rx_ts2_valid = (i < 7);
            cyc();
            clr_in();
            if (i == 14) begin
                n_chk++;
                if (ltssm_state !== 4'd2) begin
                    n_fail++; $display("FAIL poll_config_hold: state got %0d expected 2", ltssm_state);
                end
            end
        end
        n_chk++;
        if (ltssm_state !== 4'd3 || tx_mode !== 2'd0 || tx_ts_link_valid !== 1'b0) begin
            n_fail++; $display("FAIL lw_start_entry: state got %0d mode %0d lv %0d expected 3 0 0", ltssm_state, tx_mode, tx_ts_link_valid);
        end
    endtask

    task automatic test_full_training();
        rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
        reach_cfg_lw_start();
        send_ts(1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
        send_ts(1'b0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0);
        n_chk++;
        if (ltssm_state !== 4'd3) begin
            n_fail++; $display("FAIL lw_mismatch_hold: state got %0d expected 3", ltssm_state);
        end
        send_ts(1'b0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0);
        n_chk++;
        if (ltssm_state !== 4'd4 || link_id !== 5'd4 || tx_ts_link !== 5'd4 || tx_ts_link_valid !== 1'b1) begin
            n_fail++; $display("FAIL lw_pair_4: state %0d link_id %0d tx_link %0d v %0d expected 4 4 4 1", ltssm_state, link_id, tx_ts_link, tx_ts_link_valid);
        end
        send_ts(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        n_chk++;
        if (ltssm_state !== 4'd3 || tx_ts_link_valid !== 1'b0) begin
            n_fail++; $display("FAIL accept_fallback: state got %0d lv %0d expected 3 0", ltssm_state, tx_ts_link_valid);
        end
        send_ts(1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
        send_ts(1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
        n_chk++;
        if (ltssm_state !== 4'd4 || link_id !== 5'd5) begin
            n_fail++; $display("FAIL lw_pair_5: state got %0d link_id %0d expected 4 5", ltssm_state, link_id);
        end
        send_ts(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        n_chk++;
        if (ltssm_state !== 4'd5 || lane_id !== 5'd0 || tx_ts_lane_valid !== 1'b1 || tx_mode !== 2'd1) begin
            n_fail++; $display("FAIL cfg_complete_entry: state %0d lane %0d lanev %0d mode %0d expected 5 0 1 1", ltssm_state, lane_id, tx_ts_lane_valid, tx_mode);
        end
        send_ts(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tx_ts_sent = 1'b1; cyc(); clr_in();
        end
        repeat (3) send_ts(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        send_ts(1'b1, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0);
        repeat (7) send_ts(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        n_chk++;
        if (ltssm_state !== 4'd5) begin
            n_fail++; $display("FAIL cc_consecutive_reset: state got %0d expected 5", ltssm_state);
        end
        send_ts(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        n_chk++;
        if (ltssm_state !== 4'd6 || tx_mode !== 2'd2) begin
            n_fail++; $display("FAIL cfg_idle_entry: state got %0d mode %0d expected 6 2", ltssm_state, tx_mode);
        end
        rx_idle_valid = 1'b1; cyc(); clr_in();
        for (int i = 0; i < 16; i++) begin
            tx_idle_sent = 1'b1; cyc(); clr_in();
        end
        repeat (3) begin rx_idle_valid = 1'b1; cyc(); clr_in(); end
        send_ts(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        repeat (7) begin rx_idle_valid = 1'b1; cyc(); clr_in(); end
        n_chk++;
        if (ltssm_state !== 4'd6 || link_up !== 1'b0) begin
            n_fail++; $display("FAIL idle_ts_reset: state got %0d link_up %0d expected 6 0", ltssm_state, link_up);
        end
        rx_idle_valid = 1'b1; cyc(); clr_in();
        n_chk++;
        if (ltssm_state !== 4'd7 || link_up !== 1'b1 || link_id !== 5'd5 || lane_id !== 5'd0 || tx_mode !== 2'd2) begin
            n_fail++; $display("FAIL l0_entry: state %0d up %0d link %0d lane %0d mode %0d expected 7 1 5 0 2", ltssm_state, link_up, link_id, lane_id, tx_mode);
        end
    endtask

    task automatic test_retrain();
        send_ts(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        n_chk++;
        if (ltssm_state !== 4'd7 || link_up !== 1'b1) begin
            n_fail++; $display("FAIL l0_ts2_ignored: state got %0d up %0d expected 7 1", ltssm_state, link_up);
        end
        send_ts(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        n_chk++;
        if (link_up !== 1'b0 || ltssm_state !== 4'd0 || retrain_count !== 8'd1 || tx_mode !== 2'd0 || tx_ts_link_valid !== 1'b0) begin
            n_fail++; $display("FAIL retrain: up %0d state %0d retrain %0d mode %0d lv %0d expected 0 0 1 0 0", link_up, ltssm_state, retrain_count, tx_mode, tx_ts_link_valid);
        end
        cyc();
        n_chk++;
        if (ltssm_state !== 4'd1) begin
            n_fail++; $display("FAIL retrain_detect_exit: state got %0d expected 1", ltssm_state);
        end
    endtask

    task automatic test_reset_mid();
        logic [41:0] all_out;
        reach_cfg_lw_start();
        send_ts(1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
        send_ts(1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
        send_ts(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        n_chk++;
        if (ltssm_state !== 4'd5 || retrain_count !== 8'd1) begin
            n_fail++; $display("FAIL mid_reach_complete: state got %0d retrain %0d expected 5 1", ltssm_state, retrain_count);
        end
        repeat (2) send_ts(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b1);
        rst_n = 1'b0;
        tx_ts_sent = 1'b1; rx_ts2_valid = 1'b1; rx_ts_link_valid = 1'b1; rx_ts_link = 5'd5; rx_ts_lane_valid = 1'b1;
        cyc();
        clr_in();
        all_out = {ltssm_state, tx_mode, tx_ts_link_valid, tx_ts_link, tx_ts_lane_valid,
                   tx_ts_lane, link_id, lane_id, link_up, retrain_count};
        n_chk++;
        if (all_out !== 42'd0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got %h expected 0", all_out);
        end
        rst_n = 1'b1;
        cyc();
        n_chk++;
        if (ltssm_state !== 4'd1) begin
            n_fail++; $display("FAIL reset_mid_release: state got %0d expected 1", ltssm_state);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        rst_n = 1'b0;
        rst_to_n = 1'b0;
        test_reset();
        test_timeout();
        test_full_training();
        test_retrain();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
